// File: rtl/upsample_pkg.sv
// Shared constants, state encoding and address helper for the upsampler line scheduler.
package upsample_pkg;

  localparam int SLOTS_LOG2   = 3;
  localparam int SLOT_BITS    = 11;
  localparam int ADDR         = 14;
  localparam int SLOTS        = 1 << SLOTS_LOG2;
  localparam int PRIME_LINES  = 2;
  localparam int HOFFSET_BASE = 'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Read start address of a slot, pulled back by the total horizontal offset.
  // The subtraction wraps modulo the BRAM size, so slot 0 reads from the top of the ring.
  function automatic logic [ADDR-1:0] slot_base(input logic [SLOTS_LOG2-1:0] slot,
                                                input logic [7:0]            hoffset);
    logic [ADDR-1:0] offset;
    offset = ADDR'(HOFFSET_BASE) + ADDR'(hoffset);
    return {slot, {SLOT_BITS{1'b0}}} - offset;
  endfunction

endpackage

// File: rtl/upsample_line_scheduler_sync.sv
// Three-flop synchroniser that turns an asynchronous level into a one-cycle event.
// FALL_ONLY=0: any change of the level (toggle-to-pulse).
// FALL_ONLY=1: only a 1->0 transition (edge detection).
module toggle_event_sync
  import upsample_pkg::*;
#(
  parameter bit FALL_ONLY = 1'b0
) (
  input  logic clk_out,
  input  logic reset,
  input  logic i_async,
  output logic o_event
);

  // sync_q[0] = stage1, sync_q[1] = stage2, sync_q[2] = stage3
  logic [2:0] sync_q;

  // Shift the asynchronous input through three flops.
  always_ff @(posedge clk_out) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], i_async};
  end

  // Compare the two settled stages to find the event.
  always_comb begin
    if (FALL_ONLY) o_event = sync_q[2] & ~sync_q[1];
    else           o_event = sync_q[2] ^ sync_q[1];
  end

endmodule

// File: rtl/upsample_line_scheduler.sv
// Line ring-buffer scheduler: counts written PAL lines, chooses advance/repeat on
// each HD line start, tracks occupancy and overrun, and resyncs on PAL frame start.
module upsample_line_scheduler
  import upsample_pkg::*;
(
  input  logic                  clk_out,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_wr_line_tgl,
  input  logic                  i_pal_vsync,
  input  logic                  i_hd_hsync,
  input  logic [7:0]            i_hd_hoffset,
  output logic [ADDR-1:0]       o_rd_base,
  output logic [SLOTS_LOG2-1:0] o_rd_slot,
  output logic [SLOTS_LOG2-1:0] o_wr_slot,
  output logic                  o_line_start,
  output logic                  o_frame_start,
  output logic [SLOTS_LOG2:0]   o_pending,
  output logic [3:0]            o_repeat_cnt,
  output logic                  o_overrun,
  output logic [1:0]            o_state
);

  state_t                state_q, state_d;
  logic                  wr_evt, frame_evt, line_evt;
  logic [1:0]            hs_q;
  logic [SLOTS_LOG2-1:0] wr_slot_q, rd_slot_q, rd_slot_d;
  logic [SLOTS_LOG2:0]   pending_q, pending_d;
  logic [3:0]            repeat_q;
  logic                  active, wr_go, ls_go, adv, full;

  toggle_event_sync #(.FALL_ONLY(1'b0)) u_wr_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .i_async (i_wr_line_tgl),
    .o_event (wr_evt)
  );

  toggle_event_sync #(.FALL_ONLY(1'b1)) u_vs_sync (
    .clk_out (clk_out),
    .reset   (reset),
    .i_async (i_pal_vsync),
    .o_event (frame_evt)
  );

  // Two-bit hsync history; hs_q[1] is older, hs_q[0] newer.
  always_ff @(posedge clk_out) begin
    if (reset) hs_q <= '0;
    else       hs_q <= {hs_q[0], i_hd_hsync};
  end

  // Event qualification and next pointer/occupancy values.
  always_comb begin
    line_evt = ~hs_q[1] & hs_q[0];
    active   = i_enable && (state_q != ST_IDLE);
    // Frame start wins: coincident write/line events are discarded.
    wr_go    = active && wr_evt && !frame_evt;
    ls_go    = active && line_evt && !frame_evt;
    full     = (pending_q == (SLOTS_LOG2+1)'(SLOTS-1));
    adv      = ls_go && (state_q == ST_RUN) && (pending_q != '0);
    // Read pointer moves on a consumed line or when a full ring drops its oldest line.
    rd_slot_d = rd_slot_q + SLOTS_LOG2'(adv || (wr_go && full));
    pending_d = pending_q;
    if (wr_go && !adv && !full)  pending_d = pending_q + (SLOTS_LOG2+1)'(1);
    else if (adv && !wr_go)      pending_d = pending_q - (SLOTS_LOG2+1)'(1);
  end

  // State register.
  always_ff @(posedge clk_out) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (frame_evt) state_d = ST_PRIME;
        ST_PRIME: begin
          if (frame_evt)                                           state_d = ST_PRIME;
          else if (pending_q >= (SLOTS_LOG2+1)'(PRIME_LINES))      state_d = ST_RUN;
        end
        ST_RUN:   if (frame_evt) state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output mapping of state and pointers.
  always_comb begin
    o_state      = state_q;
    o_wr_slot    = wr_slot_q;
    o_rd_slot    = rd_slot_q;
    o_pending    = pending_q;
    o_repeat_cnt = repeat_q;
  end

  // Pointers, occupancy, repeat counter, overrun flag and registered read address.
  always_ff @(posedge clk_out) begin
    if (reset) begin
      wr_slot_q     <= '0;
      rd_slot_q     <= '0;
      pending_q     <= '0;
      repeat_q      <= '0;
      o_overrun     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_rd_base     <= '0;
    end else begin
      o_frame_start <= frame_evt;
      o_line_start  <= ls_go;
      if (!active || frame_evt) begin
        wr_slot_q <= '0;
        rd_slot_q <= '0;
        pending_q <= '0;
        repeat_q  <= '0;
      end else begin
        wr_slot_q <= wr_slot_q + SLOTS_LOG2'(wr_go);
        rd_slot_q <= rd_slot_d;
        pending_q <= pending_d;
        if (adv)                             repeat_q <= '0;
        else if (ls_go && repeat_q != 4'hF)  repeat_q <= repeat_q + 4'd1;
        if (wr_go && full)                   o_overrun <= 1'b1;
      end
      if (ls_go) o_rd_base <= slot_base(rd_slot_d, i_hd_hoffset);
    end
  end

endmodule

// File: tb/tb_upsample_line_scheduler.sv
// Bench for upsample_line_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an event-level model.
module tb_upsample_line_scheduler;

  logic        clk_out = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_wr_line_tgl;
  logic        i_pal_vsync;
  logic        i_hd_hsync;
  logic [7:0]  i_hd_hoffset;
  logic [13:0] o_rd_base;
  logic [2:0]  o_rd_slot;
  logic [2:0]  o_wr_slot;
  logic        o_line_start;
  logic        o_frame_start;
  logic [3:0]  o_pending;
  logic [3:0]  o_repeat_cnt;
  logic        o_overrun;
  logic [1:0]  o_state;

  upsample_line_scheduler dut (
    .clk_out       (clk_out),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_wr_line_tgl (i_wr_line_tgl),
    .i_pal_vsync   (i_pal_vsync),
    .i_hd_hsync    (i_hd_hsync),
    .i_hd_hoffset  (i_hd_hoffset),
    .o_rd_base     (o_rd_base),
    .o_rd_slot     (o_rd_slot),
    .o_wr_slot     (o_wr_slot),
    .o_line_start  (o_line_start),
    .o_frame_start (o_frame_start),
    .o_pending     (o_pending),
    .o_repeat_cnt  (o_repeat_cnt),
    .o_overrun     (o_overrun),
    .o_state       (o_state)
  );

  // ---------------- clock ----------------
  always #5 clk_out = ~clk_out;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  int fs_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input histories: x_hN is the value the input had N clock edges ago.
  bit tg_h1, tg_h2, tg_h3, vs_h1, vs_h2, vs_h3, hs_h1, hs_h2;
  int m_state = 0, m_wr = 0, m_rd = 0, m_pend = 0, m_rep = 0, m_base = 0;
  bit m_ls = 0, m_fs = 0, m_ovr = 0;
  bit e_wr, e_fs, e_ls, e_act, e_adv;
  int n_state;

  always @(posedge clk_out) begin
    if (reset) begin
      {tg_h1, tg_h2, tg_h3, vs_h1, vs_h2, vs_h3, hs_h1, hs_h2} = '0;
      m_state = 0; m_wr = 0; m_rd = 0; m_pend = 0; m_rep = 0; m_base = 0;
      m_ls = 0; m_fs = 0; m_ovr = 0;
    end else begin
      e_wr = (tg_h2 != tg_h3);
      e_fs = vs_h3 && !vs_h2;
      e_ls = hs_h1 && !hs_h2;
      n_state = m_state;
      if (!i_enable)                          n_state = 0;
      else if (e_fs)                          n_state = 1;
      else if (m_state == 1 && m_pend >= 2)   n_state = 2;
      e_act = i_enable && (m_state != 0);
      m_fs = e_fs;
      m_ls = 1'b0;
      if (!e_act || e_fs) begin
        m_wr = 0; m_rd = 0; m_pend = 0; m_rep = 0;
      end else begin
        e_adv = e_ls && (m_state == 2) && (m_pend > 0);
        if (e_wr) begin
          m_wr = (m_wr + 1) % 8;
          if (m_pend == 7) begin
            m_ovr = 1'b1;
            if (!e_adv) m_rd = (m_rd + 1) % 8;
          end else if (!e_adv) begin
            m_pend = m_pend + 1;
          end
        end
        if (e_adv) begin
          m_rd = (m_rd + 1) % 8;
          if (!e_wr) m_pend = m_pend - 1;
          m_rep = 0;
        end else if (e_ls) begin
          m_rep = (m_rep < 15) ? m_rep + 1 : 15;
        end
        if (e_ls) begin
          m_ls = 1'b1;
          m_base = (m_rd * 2048 - (128 + int'(i_hd_hoffset)) + 16384) % 16384;
        end
      end
      m_state = n_state;
      tg_h3 = tg_h2; tg_h2 = tg_h1; tg_h1 = i_wr_line_tgl;
      vs_h3 = vs_h2; vs_h2 = vs_h1; vs_h1 = i_pal_vsync;
      hs_h2 = hs_h1; hs_h1 = i_hd_hsync;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_out) begin
    if (o_frame_start) fs_seen++;
    if (cmp_en) begin
      chk("state",       o_state,       m_state);
      chk("wr_slot",     o_wr_slot,     m_wr);
      chk("rd_slot",     o_rd_slot,     m_rd);
      chk("pending",     o_pending,     m_pend);
      chk("repeat_cnt",  o_repeat_cnt,  m_rep);
      chk("rd_base",     o_rd_base,     m_base);
      chk("line_start",  o_line_start,  m_ls);
      chk("frame_start", o_frame_start, m_fs);
      chk("overrun",     o_overrun,     m_ovr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_out);
  endtask

  task automatic wr_line();
    i_wr_line_tgl = ~i_wr_line_tgl;
    tick(4);
  endtask

  task automatic hd_line();
    i_hd_hsync = 1'b1;
    tick(2);
    i_hd_hsync = 1'b0;
    tick(3);
  endtask

  task automatic frame();
    i_pal_vsync = 1'b1;
    tick(4);
    i_pal_vsync = 1'b0;
    tick(5);
  endtask

  // Check a DUT output and the model against the same hand-computed value.
  task automatic pin(input string name, input int dut_val, input int model_val, input int lit);
    chk(name, dut_val, lit);
    chk({name, "_model"}, model_val, lit);
  endtask

  // ---------------- stimulus ----------------
  int fs_before;

  initial begin
    reset = 1'b1; i_enable = 1'b0; i_wr_line_tgl = 1'b0;
    i_pal_vsync = 1'b0; i_hd_hsync = 1'b0; i_hd_hoffset = 8'h00;
    tick(3);
    cmp_en = 1'b1;
    pin("rst_state",   o_state,   m_state, 0);
    pin("rst_rd_base", o_rd_base, m_base,  0);
    pin("rst_pending", o_pending, m_pend,  0);
    pin("rst_overrun", o_overrun, m_ovr,   0);
    reset = 1'b0; i_enable = 1'b1;
    tick(2);

    // Priming: two line starts repeat slot 0, then two writes reach RUN.
    frame();
    pin("prime_state", o_state, m_state, 1);
    hd_line();
    pin("prime_base1", o_rd_base, m_base, 'h3F80);
    hd_line();
    pin("prime_base2", o_rd_base, m_base, 'h3F80);
    pin("prime_rep",   o_repeat_cnt, m_rep, 2);
    wr_line();
    wr_line();
    pin("run_state",   o_state,   m_state, 2);
    pin("run_pending", o_pending, m_pend,  2);
    hd_line();
    pin("adv_base",    o_rd_base, m_base, 'h0780);
    pin("adv_rd_slot", o_rd_slot, m_rd,   1);

    // Repeat: drain to pending 0, then four line starts hold the slot.
    hd_line();
    pin("drain_pending", o_pending, m_pend, 0);
    repeat (4) hd_line();
    pin("rep_cnt",     o_repeat_cnt, m_rep,  4);
    pin("rep_rd_slot", o_rd_slot,    m_rd,   2);
    pin("rep_base",    o_rd_base,    m_base, 'h0F80);

    // Coincidence: write and line start land on the same edge with pending 1.
    wr_line();
    pin("coin_pre_pending", o_pending, m_pend, 1);
    i_wr_line_tgl = ~i_wr_line_tgl;
    tick(1);
    i_hd_hsync = 1'b1;
    tick(2);
    i_hd_hsync = 1'b0;
    tick(4);
    pin("coin_pending", o_pending, m_pend, 1);
    pin("coin_rd_slot", o_rd_slot, m_rd,   3);
    pin("coin_wr_slot", o_wr_slot, m_wr,   4);

    // Resync: frame start together with a write event in RUN.
    i_pal_vsync = 1'b1;
    tick(4);
    fs_before = fs_seen;
    i_pal_vsync = 1'b0;
    i_wr_line_tgl = ~i_wr_line_tgl;
    tick(6);
    pin("resync_state",   o_state,   m_state, 1);
    pin("resync_wr_slot", o_wr_slot, m_wr,    0);
    pin("resync_pending", o_pending, m_pend,  0);
    chk("resync_fs_pulses", fs_seen - fs_before, 1);

    // Offset wrap on slot 0.
    i_hd_hoffset = 8'hFF;
    hd_line();
    i_hd_hoffset = 8'h00;
    pin("wrap_base", o_rd_base, m_base, 'h3E81);

    // Overrun: eight writes without line starts.
    repeat (8) wr_line();
    pin("ovr_pending", o_pending, m_pend, 7);
    pin("ovr_flag",    o_overrun, m_ovr,  1);
    pin("ovr_rd_slot", o_rd_slot, m_rd,   1);
    pin("ovr_wr_slot", o_wr_slot, m_wr,   0);

    // Disable forces IDLE; overrun stays sticky.
    i_enable = 1'b0;
    tick(2);
    pin("dis_state",   o_state,   m_state, 0);
    pin("dis_pending", o_pending, m_pend,  0);
    pin("dis_overrun", o_overrun, m_ovr,   1);
    i_enable = 1'b1;

    // Randomized traffic with varying write/line rates and a mid-run reset.
    for (int seg = 0; seg < 12; seg++) begin
      int wr_rate;
      int hs_rate;
      wr_rate = $urandom_range(2, 12);
      hs_rate = $urandom_range(2, 12);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk_out);
        if ($urandom_range(1, wr_rate) == 1) i_wr_line_tgl = ~i_wr_line_tgl;
        if ($urandom_range(1, hs_rate) == 1) i_hd_hsync = ~i_hd_hsync;
        if ($urandom_range(0, 59) == 0)      i_pal_vsync = ~i_pal_vsync;
        i_enable     = ($urandom_range(0, 399) != 0);
        i_hd_hoffset = 8'($urandom_range(0, 255));
        reset        = (seg == 6 && c < 2);
      end
    end
    i_hd_hsync = 1'b0;
    tick(6);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
